// File: rtl/matrix_pkg.sv
// Shared constants and pixel-index helper for the 6x6 LED matrix scan driver.
package matrix_pkg;

  localparam int unsigned MATRIX_ROWS = 6;
  localparam int unsigned MATRIX_COLS = 6;
  localparam int unsigned IMG_W       = MATRIX_ROWS * MATRIX_COLS;
  localparam int unsigned BRI_W       = 3;
  localparam int unsigned BRI_LEVELS  = 1 << BRI_W;

  // Bit position of pixel (r, c) inside a frame image.
  function automatic int unsigned pix(input int unsigned r, input int unsigned c);
    return MATRIX_COLS * r + c;
  endfunction

endpackage

// File: rtl/matrix_slot_timer.sv
// Free-running row-slot timer: slot counter within a row slot and the row index.
module matrix_slot_timer #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned SLOT = 2016,
  parameter int unsigned CW   = $clog2(SLOT),
  parameter int unsigned RW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] slot_cnt_o,
  output logic [RW-1:0] row_idx_o,
  output logic          slot_end_o,
  output logic          frame_end_o
);

  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [RW-1:0] row_idx_q, row_idx_d;
  logic          slot_end_q, slot_end_d;
  logic          frame_end_q, frame_end_d;

  // Next-state counters; strobes are precomputed so they line up with the counter value they describe.
  always_comb begin
    slot_cnt_d = slot_cnt_q + CW'(1);
    row_idx_d  = row_idx_q;
    if (slot_cnt_q == CW'(SLOT - 1)) begin
      slot_cnt_d = '0;
      row_idx_d  = (row_idx_q == RW'(ROWS - 1)) ? '0 : row_idx_q + RW'(1);
    end
    slot_end_d  = (slot_cnt_d == CW'(SLOT - 1));
    frame_end_d = slot_end_d && (row_idx_d == RW'(ROWS - 1));
  end

  // Counter and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q  <= '0;
      row_idx_q   <= '0;
      slot_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      row_idx_q   <= row_idx_d;
      slot_end_q  <= slot_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign slot_cnt_o  = slot_cnt_q;
  assign row_idx_o   = row_idx_q;
  assign slot_end_o  = slot_end_q;
  assign frame_end_o = frame_end_q;

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed scan driver: double-buffered frame, guard interval, 8-level PWM.
module led_matrix_scan
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS         = MATRIX_ROWS,
  parameter int unsigned COLS         = MATRIX_COLS,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter int unsigned STEP_CYCLES  = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IMG_W-1:0] img,
  input  logic             img_valid,
  input  logic [BRI_W-1:0] brightness,
  input  logic             blank,
  output logic [ROWS-1:0]  row,
  output logic [COLS-1:0]  col,
  output logic             frame_start
);

  localparam int unsigned SLOT = GUARD_CYCLES + BRI_LEVELS * STEP_CYCLES;
  localparam int unsigned CW   = $clog2(SLOT);
  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned PW   = CW + 1;

  logic [CW-1:0]    slot_cnt;
  logic [RW-1:0]    row_idx;
  logic             slot_end;
  logic             frame_end;

  logic [IMG_W-1:0] shadow_q;
  logic [IMG_W-1:0] active_q;
  logic [BRI_W-1:0] bri_q;
  logic             started_q;

  logic [ROWS-1:0]  row_q, row_d;
  logic [COLS-1:0]  col_q, col_d;
  logic             frame_start_q, frame_start_d;

  logic [PW-1:0]    slot_ext;
  logic [PW-1:0]    win_end;
  logic             lit;

  matrix_slot_timer #(
    .ROWS (ROWS),
    .SLOT (SLOT),
    .CW   (CW),
    .RW   (RW)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .slot_cnt_o  (slot_cnt),
    .row_idx_o   (row_idx),
    .slot_end_o  (slot_end),
    .frame_end_o (frame_end)
  );

  // Shadow/active double buffer; a strobe on the boundary cycle bypasses straight into active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (img_valid) begin
        shadow_q <= img;
      end
      if (frame_end) begin
        active_q <= img_valid ? img : shadow_q;
      end
    end
  end

  // Brightness is latched at the end of each slot so a slot never changes width mid-way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bri_q     <= '0;
      started_q <= 1'b0;
    end else begin
      if (slot_end) begin
        bri_q <= brightness;
      end
      started_q <= 1'b1;
    end
  end

  // Lit-window compare and next output values.
  always_comb begin
    slot_ext      = PW'(slot_cnt);
    win_end       = PW'(GUARD_CYCLES) + (PW'(bri_q) + PW'(1)) * PW'(STEP_CYCLES);
    lit           = !blank && (slot_ext >= PW'(GUARD_CYCLES)) && (slot_ext < win_end);
    row_d         = '0;
    col_d         = '1;
    frame_start_d = started_q && (slot_cnt == '0) && (row_idx == '0);
    if (lit) begin
      row_d = ROWS'(1) << row_idx;
      col_d = ~active_q[pix(32'(row_idx), 0) +: COLS];
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q         <= '0;
      col_q         <= '1;
      frame_start_q <= 1'b0;
    end else begin
      row_q         <= row_d;
      col_q         <= col_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign row         = row_q;
  assign col         = col_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan with a cycle-count reference model.
module tb_led_matrix_scan;

  localparam int unsigned G     = 2;
  localparam int unsigned ST    = 4;
  localparam int unsigned SLOT  = G + 8 * ST;
  localparam int unsigned NR    = 6;
  localparam int unsigned FRAME = NR * SLOT;

  logic        clk;
  logic        rst_n;
  logic [35:0] img;
  logic        img_valid;
  logic [2:0]  brightness;
  logic        blank;
  logic [5:0]  row;
  logic [5:0]  col;
  logic        frame_start;

  led_matrix_scan #(
    .ROWS         (6),
    .COLS         (6),
    .GUARD_CYCLES (G),
    .STEP_CYCLES  (ST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .img         (img),
    .img_valid   (img_valid),
    .brightness  (brightness),
    .blank       (blank),
    .row         (row),
    .col         (col),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  row;
    logic [5:0]  col;
    logic        fs;
    int unsigned t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: everything derives from the cycle count since reset release.
  int unsigned t;
  logic [35:0] m_shadow;
  logic [35:0] m_active;
  int unsigned m_bri;

  function automatic exp_t model_out();
    exp_t        e;
    int unsigned r   = (t / SLOT) % NR;
    int unsigned s   = t % SLOT;
    bit          lit = !blank && (s >= G) && (s < G + (m_bri + 1) * ST);
    e.t   = t;
    e.fs  = (t % FRAME == 0) && (t != 0);
    e.row = '0;
    e.col = '1;
    if (lit) begin
      e.row[r] = 1'b1;
      for (int c = 0; c < 6; c++) e.col[c] = !m_active[r * 6 + c];
    end
    return e;
  endfunction

  task automatic model_step();
    int unsigned r = (t / SLOT) % NR;
    int unsigned s = t % SLOT;
    if (img_valid) m_shadow = img;
    if (s == SLOT - 1 && r == NR - 1) m_active = m_shadow;
    if (s == SLOT - 1) m_bri = brightness;
    t++;
  endtask

  task automatic model_reset();
    t        = 0;
    m_shadow = '0;
    m_active = '0;
    m_bri    = 0;
  endtask

  // One clock cycle with the current inputs; called at posedge+1.
  task automatic cyc();
    exp_t e;
    e = model_out();
    model_step();
    @(posedge clk);
    q.push_back(e);
    #1;
    img_valid = 1'b0;
  endtask

  task automatic run_until(input int unsigned tt);
    while (t < tt) cyc();
  endtask

  task automatic strobe(input logic [35:0] v);
    img       = v;
    img_valid = 1'b1;
    cyc();
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (row !== 6'h00 || col !== 6'h3F || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL %s row=%b col=%b fs=%b required row=000000 col=111111 fs=0",
               name, row, col, frame_start);
    end
  endtask

  // Async reset pulse placed mid-cycle, away from the monitor's sampling point.
  task automatic mid_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_hold");
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: every output cycle has an expected entry to pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (row !== e.row || col !== e.col || frame_start !== e.fs) begin
          errors++;
          $display("FAIL scan t=%0d row=%b exp %b col=%b exp %b fs=%b exp %b",
                   e.t, row, e.row, col, e.col, frame_start, e.fs);
        end
      end
    end
  end

  initial begin
    logic [35:0] a;
    rst_n      = 1'b0;
    img        = '0;
    img_valid  = 1'b0;
    brightness = 3'd7;
    blank      = 1'b0;
    model_reset();

    repeat (5) begin
      @(posedge clk);
      #1;
      check_reset("power_on_reset");
    end
    rst_n = 1'b1;

    // First frame stays dark; frame load of a single pixel mid-frame 1.
    run_until(FRAME + 50);
    strobe(36'h1);

    // Tearing: A in row 2, B in row 4 of the same frame.
    a = {$urandom(), $urandom()} >> 28;
    run_until(3 * FRAME + 2 * SLOT + 10);
    strobe(a);
    run_until(3 * FRAME + 4 * SLOT + 10);
    strobe(~a);

    // Boundary bypass on the exact frame-end cycle.
    run_until(6 * FRAME - 1);
    strobe(36'hF_FFFF_FFFF);

    // Brightness 0, then 3 mid-slot.
    run_until(6 * FRAME + 16);
    brightness = 3'd0;
    run_until(6 * FRAME + 2 * SLOT + 10);
    brightness = 3'd3;

    // Blank for 10 cycles inside a lit window.
    run_until(6 * FRAME + 4 * SLOT + 5);
    blank = 1'b1;
    repeat (10) cyc();
    blank = 1'b0;

    // Async reset during row 3 of the next frame.
    run_until(7 * FRAME + 3 * SLOT + 10);
    mid_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        img       = 36'({$urandom(), $urandom()});
        img_valid = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) brightness = 3'($urandom_range(0, 7));
      blank = ($urandom_range(0, 99) < 4);
      cyc();
    end
    blank = 1'b0;
    repeat (3) cyc();

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Row-multiplexed scan driver for the 6x6 LED matrix FeatherWing. It sits directly downstream of the game/display logic: it accepts a 36-bit frame image, double-buffers it so frames never tear, and drives the `row`/`col` pins. Each row is lit in turn with an anti-ghosting guard interval and 8-level PWM brightness.

## Interface
Parameters:
- `ROWS`, 6: matrix rows.
- `COLS`, 6: matrix columns.
- `GUARD_CYCLES`, 16: all-off cycles at the start of each row slot.
- `STEP_CYCLES`, 250: cycles per brightness step. Row slot = `GUARD_CYCLES + 8*STEP_CYCLES`.

Ports:
- `clk`  in  1: system clock. One clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `img`  in  36: frame image. Bit `6*r + c` is row r, column c; 1 = LED on.
- `img_valid`  in  1: one-cycle strobe; load `img` into the shadow buffer.
- `brightness`  in  3: 0 = dimmest (1/8 lit window), 7 = full.
- `blank`  in  1: force all LEDs off. Scanning continues.
- `row`  out  6: one-hot, active-high row select.
- `col`  out  6: active-low column sink. `col[c]=0` lights column c.
- `frame_start`  out  1: one-cycle pulse on the first output cycle of the row-0 slot.

## Operation
- Reset values: `row=6'b000000`, `col=6'b111111`, `frame_start=0`. Shadow and active buffers cleared. `row_idx=0`, `slot_cnt=0`.
- Counters:
  - `slot_cnt` counts 0..SLOT-1, then wraps to 0 and advances `row_idx`.
  - `row_idx` counts 0..ROWS-1, then wraps to 0.
  - Both run continuously from reset release.
- Shadow buffer: loads `img` on any cycle with `img_valid=1`. The last strobe before a frame boundary wins.
- Frame boundary is the cycle where `slot_cnt==SLOT-1` and `row_idx==ROWS-1`. On that cycle the active buffer loads from the shadow buffer.
  - If `img_valid` is asserted on the boundary cycle, the active buffer loads `img` directly (bypass) and the shadow buffer also loads it.
- Brightness: `brightness` is sampled into `bri_q` on each cycle where `slot_cnt==SLOT-1`, and stays constant for the whole following slot.
- Lit window: `GUARD_CYCLES <= slot_cnt < GUARD_CYCLES + (bri_q+1)*STEP_CYCLES`, and `blank=0`.
- Inside the lit window:
  - `row = 1<<row_idx`.
  - `col = ~active[6*row_idx +: 6]`.
- Outside the lit window: `row=0`, `col=6'b111111`. This covers the guard interval, PWM off-time, and `blank`.
- `blank` is not sampled; it takes effect on the next output cycle.

## Timing
- All outputs are registered. The outputs on cycle n reflect the counter, `active`, `bri_q` and `blank` state of cycle n-1.
- Latency:
  - `img_valid` to pixels visible: until the next frame boundary, plus 1 cycle, plus `GUARD_CYCLES` before row 0 lights.
  - `blank`: 1 cycle.
- `frame_start` asserts on the same cycle the outputs show `slot_cnt=0`, `row_idx=0`. It does not assert on the first cycle after reset release.
- Frame period = `ROWS*SLOT` cycles. With the default parameters this is 6*2016 = 12096 cycles.
- Counter widths: `slot_cnt` is $clog2(SLOT) bits. The product `(bri_q+1)*STEP_CYCLES` is computed at $clog2(SLOT)+1 bits, with no overflow at `bri_q=7`.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronous). After release, scanning restarts at row 0, slot 0, with an empty active buffer. The first frame boundary then loads the shadow buffer.

## Structure
- Shared package `matrix_pkg`:
  - `MATRIX_ROWS=6`, `MATRIX_COLS=6`, `IMG_W=36`, `BRI_W=3`.
  - Bit-index helper `pix(r,c)=6*r+c`.
- One sub-module, `matrix_slot_timer`:
  - Holds `slot_cnt` and `row_idx`.
  - Outputs `slot_cnt`, `row_idx`, `slot_end` and `frame_end` strobes.
- The top level holds the buffers, `bri_q`, the lit-window compare and the output registers.

## Test plan
All scenarios use `GUARD_CYCLES=2`, `STEP_CYCLES=4`, so SLOT=34 and the frame is 204 cycles.

- Reset: hold `rst_n=0` for 5 cycles, then release.
  - Required: `row=0`, `col=6'h3F` throughout the first frame (active buffer empty).
  - Required: `frame_start` first pulses 205 cycles after release.
- Frame load: with `brightness=7`, strobe `img=36'h1` mid-frame.
  - Required: after the next boundary, the row-0 slot shows `row=6'b000001`, `col=6'b111110` for output cycles 2..33 of the slot.
  - Required: `row=0` on output cycles 0..1 of the slot.
- Tearing: strobe `img=A` in row 2 of a frame, then `img=B` in row 4 of the same frame.
  - Required: only B is ever displayed. A never appears.
- Boundary bypass: assert `img_valid` with `img=36'hFFFFFFFFF` exactly on the frame-end cycle.
  - Required: the next frame shows all rows with `col=0`.
- Brightness: `brightness=0`.
  - Required: each row is lit for exactly 4 cycles (slot cycles 2..5).
  - Required: changing `brightness` to 3 mid-slot has no effect until the next slot, which is then lit for 16 cycles.
- Blank and reset during operation:
  - `blank=1` for 10 cycles during a lit window: required `row=0`, `col=6'h3F` starting 1 cycle later.
  - Async `rst_n` pulse during row 3: required outputs return to reset values within the same cycle, and scanning restarts at row 0.
